// File: rtl/led_frame_tx.sv
// Ping-pong LED frame buffer and serialiser for a daisy-chained MiniLED driver chain.
// The generator fills one bank while the other is shifted out over dclk/sdi/le.

module led_frame_tx #(
  parameter int unsigned NUM_LED  = 360,
  parameter int unsigned HALF_DIV = 2,
  parameter int unsigned LE_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [9:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        frame_sync,
  output logic        dclk,
  output logic        sdi,
  output logic        le,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_drop
);

  localparam int unsigned DW = $clog2(HALF_DIV) + 1;
  localparam int unsigned LW = $clog2(LE_LEN) + 1;
  localparam int unsigned AW = $clog2(2 * NUM_LED);

  localparam logic [9:0]    LastIdx = 10'(NUM_LED - 1);
  localparam logic [DW-1:0] DivHalf = DW'(HALF_DIV);
  localparam logic [DW-1:0] DivLast = DW'(2 * HALF_DIV - 1);
  localparam logic [LW-1:0] LeLast  = LW'(LE_LEN - 1);
  localparam logic [AW-1:0] BankOfs = AW'(NUM_LED);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StLatch
  } state_e;

  state_e         state_q, state_d;
  logic           wr_bank_q, wr_bank_d;
  logic [9:0]     word_idx_q, word_idx_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic [LW-1:0]  le_cnt_q, le_cnt_d;
  logic           load_ph_q, load_ph_d;
  logic [15:0]    shift_q, shift_d;
  logic           sync_q, sync_qq;
  logic           rise;

  // Both banks share one array; bank 1 sits above bank 0 at offset NUM_LED.
  logic [15:0]    mem [2*NUM_LED];
  logic [15:0]    rd_data;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           wr_ok;

  assign wr_ok  = wr_en && (wr_addr <= LastIdx);
  assign wr_ptr = wr_bank_q ? (BankOfs + AW'(wr_addr)) : AW'(wr_addr);
  assign rd_ptr = wr_bank_q ? AW'(word_idx_q) : (BankOfs + AW'(word_idx_q));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
    rd_data <= mem[rd_ptr];
  end

  assign rise = sync_q & ~sync_qq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_bank_q  <= 1'b0;
      word_idx_q <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      le_cnt_q   <= '0;
      load_ph_q  <= 1'b0;
      shift_q    <= '0;
      sync_q     <= 1'b0;
      sync_qq    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      word_idx_q <= word_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      le_cnt_q   <= le_cnt_d;
      load_ph_q  <= load_ph_d;
      shift_q    <= shift_d;
      sync_q     <= frame_sync;
      sync_qq    <= sync_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    word_idx_d = word_idx_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    le_cnt_d   = le_cnt_q;
    load_ph_d  = load_ph_q;
    shift_d    = shift_q;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          wr_bank_d  = ~wr_bank_q;
          word_idx_d = '0;
          load_ph_d  = 1'b0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        // Phase 0 presents the read address; phase 1 takes the registered RAM output.
        if (!load_ph_q) begin
          load_ph_d = 1'b1;
        end else begin
          load_ph_d = 1'b0;
          shift_d   = rd_data;
          bit_cnt_d = 4'd15;
          div_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          shift_d   = {shift_q[14:0], 1'b0};
          if (bit_cnt_q == 4'd0) begin
            if (word_idx_q == LastIdx) begin
              le_cnt_d = '0;
              state_d  = StLatch;
            end else begin
              word_idx_d = word_idx_q + 10'd1;
              state_d    = StLoad;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
      end
      StLatch: begin
        le_cnt_d = le_cnt_q + 1'b1;
        if (le_cnt_q == LeLast) begin
          le_cnt_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  always_comb begin
    dclk       = (state_q == StShift) && (div_cnt_q >= DivHalf);
    sdi        = (state_q == StShift) && shift_q[15];
    le         = (state_q == StLatch);
    busy       = (state_q != StIdle);
    frame_done = (state_q == StLatch) && (le_cnt_q == LeLast);
    frame_drop = rise && (state_q != StIdle);
  end

endmodule

// File: tb/tb_led_frame_tx.sv
// Directed bench for led_frame_tx: decodes the serial stream and checks frame shape and contents.

module tb_led_frame_tx;

  localparam int NLed      = 360;
  localparam int FrameCyc  = 23764;
  localparam int EdgeCount = 5760;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_sync;
  logic        dclk, sdi, le, busy, frame_done, frame_drop;

  int n_checks = 0;
  int n_fail   = 0;

  led_frame_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_sync (frame_sync),
    .dclk       (dclk),
    .sdi        (sdi),
    .le         (le),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_drop (frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream monitor, sampled on the falling clock edge.
  int          clr_req = 0;
  int          clr_ack = 0;
  int          edges, bits, nwords, le_cyc, done_cnt, busy_cyc, drop_cnt, unstable;
  logic [15:0] cur;
  logic [15:0] words [NLed];
  logic        dclk_p, sdi_p;

  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      clr_ack  = clr_req;
      edges    = 0;
      bits     = 0;
      nwords   = 0;
      le_cyc   = 0;
      done_cnt = 0;
      busy_cyc = 0;
      drop_cnt = 0;
      unstable = 0;
      cur      = '0;
    end
    if (dclk === 1'b1 && dclk_p === 1'b0) begin
      cur   = {cur[14:0], sdi};
      edges = edges + 1;
      bits  = bits + 1;
      if (bits == 16) begin
        if (nwords < NLed) words[nwords] = cur;
        nwords = nwords + 1;
        bits   = 0;
      end
    end
    if (dclk === 1'b1 && dclk_p === 1'b1 && sdi !== sdi_p) unstable = unstable + 1;
    if (le === 1'b1)         le_cyc   = le_cyc + 1;
    if (frame_done === 1'b1) done_cnt = done_cnt + 1;
    if (busy === 1'b1)       busy_cyc = busy_cyc + 1;
    if (frame_drop === 1'b1) drop_cnt = drop_cnt + 1;
    dclk_p = dclk;
    sdi_p  = sdi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_req++;
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = 10'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < FrameCyc + 2000 && busy === 1'b1; i++) tick();
    check("frame_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame_shape(input int exp_drop);
    check("word_count",   nwords,   NLed);
    check("dclk_edges",   edges,    EdgeCount);
    check("le_cycles",    le_cyc,   4);
    check("done_pulses",  done_cnt, 1);
    check("busy_cycles",  busy_cyc, FrameCyc);
    check("drop_pulses",  drop_cnt, exp_drop);
    check("sdi_unstable", unstable, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    frame_sync = 1'b0;
    #3;
    check("rst_dclk",  {31'd0, dclk},       32'd0);
    check("rst_sdi",   {31'd0, sdi},        32'd0);
    check("rst_le",    {31'd0, le},         32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_done",  {31'd0, frame_done}, 32'd0);
    check("rst_drop",  {31'd0, frame_drop}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Frame to be aborted by reset at word 100.
    for (int i = 0; i < NLed; i++) wr(i, 16'(i * 257));
    clear_mon();
    frame_sync = 1'b1;
    tick();
    tick();
    frame_sync = 1'b0;
    // Bank 1 word 0 is written here and must survive to the last frame.
    wr(0, 16'hABCD);
    for (int i = 0; i < 10000 && nwords < 100; i++) tick();
    check("abort_reach_w100", {31'd0, nwords >= 100}, 32'd1);
    for (int i = 0; i < 8 && dclk !== 1'b1; i++) tick();
    check("abort_dclk_high", {31'd0, dclk}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_dclk", {31'd0, dclk}, 32'd0);
    check("abort_sdi",  {31'd0, sdi},  32'd0);
    check("abort_le",   {31'd0, le},   32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) tick();
    check("no_resume_busy", {31'd0, busy}, 32'd0);
    check("no_resume_dclk", {31'd0, dclk}, 32'd0);

    // Load pattern into bank 0 plus an out-of-range write that must be dropped.
    for (int i = 0; i < NLed; i++) wr(i, 16'(i * 257));
    wr(360, 16'hFFFF);
    clear_mon();
    frame_sync = 1'b1;
    tick();
    // Write in the swap cycle belongs to the frame being committed.
    wr(5, 16'h5555);
    check("busy_after_swap", {31'd0, busy}, 32'd1);
    frame_sync = 1'b0;
    repeat (996) tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int i = 1; i < NLed; i++) wr(i, 16'hABCD);
    wait_idle();
    check_frame_shape(1);
    for (int i = 0; i < NLed; i++) begin
      check($sformatf("f1_word%0d", i), {16'd0, words[i]},
            {16'd0, (i == 5) ? 16'h5555 : 16'(i * 257)});
    end

    // Third sync sends the bank filled during the previous frame.
    tick();
    clear_mon();
    frame_sync = 1'b1;
    repeat (3) tick();
    frame_sync = 1'b0;
    wait_idle();
    check_frame_shape(0);
    for (int i = 0; i < NLed; i++) begin
      check($sformatf("f2_word%0d", i), {16'd0, words[i]}, 32'h0000ABCD);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_frame_tx.md
Name: led_frame_tx

Overview:
- Downstream stage of the LED brightness write generator.
- Captures the per-LED 16-bit brightness words the generator writes (address, data, frame flag) into a ping-pong frame buffer.
- On each frame flag, serialises the completed frame to the daisy-chained MiniLED driver ICs over DCLK/SDI/LE.
- Decouples the generator's write timing from the driver's serial timing.

Parameters:
- NUM_LED, 360, number of LEDs (words) per frame.
- HALF_DIV, 2, clk cycles per DCLK half-period; must be >= 1.
- LE_LEN, 4, clk cycles LE is held high after the last bit.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for wr_addr/wr_data.
- wr_addr  in  10  LED index 0..NUM_LED-1.
- wr_data  in  16  brightness word, sent MSB first.
- frame_sync  in  1  frame flag (sdbpflag); its rising edge commits the write bank.
- dclk  out  1  serial clock to driver chain.
- sdi  out  1  serial data; stable while dclk is high.
- le  out  1  latch enable to driver chain.
- busy  out  1  high from bank swap until the end of LATCH.
- frame_done  out  1  one-cycle pulse at the end of LATCH.
- frame_drop  out  1  one-cycle pulse when a frame_sync edge is rejected.

Behaviour:
- Reset:
  - dclk, sdi, le, busy, frame_done and frame_drop are 0.
  - State is IDLE; wr_bank=0; word_idx=0.
  - Buffer RAM contents are not reset.
- Buffer:
  - Two banks of NUM_LED x 16 bits.
  - Writes go to bank wr_bank. Reads use !wr_bank with 1-cycle registered read latency.
  - A write with wr_en=1 and wr_addr>=NUM_LED is ignored.
  - Writes are accepted in every state, including during transmission.
- Sync detection:
  - frame_sync is registered once; rise = sync_q & ~sync_qq.
  - The swap occurs in the cycle after rise is detected.
  - A write in the same cycle as the swap goes to the old write bank, so it is included in the committed frame.
- FSM states and transitions:
  - IDLE: on rise, toggle wr_bank, set busy=1, set word_idx=0, go to LOAD.
  - LOAD, 2 cycles: cycle 1 presents read address word_idx; cycle 2 loads the shift register with the read data and sets bit_cnt=15. dclk=0. Go to SHIFT.
  - SHIFT, 16 bits x 2*HALF_DIV cycles per bit:
    - sdi = shift[15] for the whole bit period.
    - dclk is 0 for the first HALF_DIV cycles and 1 for the second HALF_DIV cycles.
    - At the end of each bit, shift left.
    - After bit 0: if word_idx==NUM_LED-1 go to LATCH; otherwise increment word_idx and go to LOAD.
  - LATCH: dclk=0, sdi=0, le=1 for LE_LEN cycles. On the last cycle, frame_done=1. Next cycle: busy=0, state IDLE.
- Rejected sync: a rise in any state other than IDLE produces frame_drop=1 for 1 cycle, with no swap and no restart. The write bank keeps accumulating and is committed at the next accepted sync.
- Frame duration: NUM_LED*(2+32*HALF_DIV)+LE_LEN cycles, which is 23764 cycles at the defaults.
- Reset asserted mid-frame: all outputs return to their reset values immediately; the aborted frame is not resumed.
- Counter widths: word_idx is 10 bits, bit_cnt 4 bits, the divider counter clog2(HALF_DIV)+1 bits, the LE counter clog2(LE_LEN)+1 bits. No counter wraps in normal operation.

Test Plan:
- Load pattern: write word[i]=i*0x0101 for i=0..359, then pulse frame_sync. Required: the decoded SDI stream sampled on dclk rising edges equals 0x0000, 0x0101, …, MSB first; exactly 5760 dclk rising edges; le high for 4 cycles; one frame_done pulse; busy high for 23764 cycles.
- Out-of-range write: wr_addr=360 with data 0xFFFF. Required: no word in the next frame changes.
- Sync while busy: a second frame_sync rise 1000 cycles after the first. Required: frame_drop pulses once and the transmission is unaffected. A third sync after frame_done then sends the data written in the meantime.
- Ping-pong isolation: during transmission of frame A (all 0x1234), write all 0xABCD. Required: frame A transmits all 0x1234; the next sync transmits all 0xABCD.
- Same-cycle write and swap: write addr 5 = 0x5555 in the swap cycle. Required: word 5 of that frame is 0x5555.
- Reset mid-SHIFT at word 100. Required: dclk/sdi/le/busy are 0 in the same cycle. After release, a new sync produces a complete 360-word frame.
